// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: ROM byte port, redirect request and decoder handshake.
// master = instr_fetch, slave = ROM / decoder / branch unit side.
interface instr_fetch_if;
  logic [31:0] rom_addr;
  logic [7:0]  rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_word;
  logic [31:0] instr_pc;
  logic [31:0] fetch_pc;

  modport master (
    output rom_addr, instr_valid, instr_word, instr_pc, fetch_pc,
    input  rom_data, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  rom_addr, instr_valid, instr_word, instr_pc, fetch_pc,
    output rom_data, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Byte-serial instruction fetch: assembles 4 ROM bytes per word into a small FIFO.
// Define FETCH_BIG_ENDIAN_EN to place the lowest-address byte in [31:24].
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned ROM_BYTES  = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);
  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] PC_MASK   = 32'(ROM_BYTES - 1);
  localparam logic [31:0] WORD_MASK = PC_MASK & ~32'h3;
  localparam logic [31:0] START_PC  = RESET_PC & WORD_MASK;

  typedef enum logic [1:0] {FETCH, STALL, FLUSH} state_t;

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic [1:0]  r_byte_cnt;
  logic [7:0]  r_lane0;
  logic [7:0]  r_lane1;
  logic [7:0]  r_lane2;
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [31:0] r_mem_word [FIFO_DEPTH];
  logic [31:0] r_mem_pc   [FIFO_DEPTH];
  logic [31:0] r_head_word;
  logic [31:0] r_head_pc;

  logic [AW:0] w_count;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_slot_free;
  logic        w_at_last;
  logic        w_push;
  logic [AW:0] w_rd_nxt;
  logic [AW:0] w_wr_nxt;
  logic [31:0] w_word;
  logic [31:0] w_next_pc;
  logic [31:0] w_head_word_nxt;
  logic [31:0] w_head_pc_nxt;

  assign w_count     = r_wr_ptr - r_rd_ptr;
  assign w_empty     = (w_count == '0);
  assign w_full      = (w_count == (AW + 1)'(FIFO_DEPTH));
  assign w_pop       = bus.instr_ready && !w_empty;
  assign w_slot_free = !w_full || w_pop;
  assign w_at_last   = ((r_state == FETCH) || (r_state == STALL)) && (r_byte_cnt == 2'd3);
  assign w_push      = w_at_last && w_slot_free && !bus.redirect_valid;
  assign w_rd_nxt    = r_rd_ptr + {{AW{1'b0}}, w_pop};
  assign w_wr_nxt    = r_wr_ptr + {{AW{1'b0}}, w_push};
  assign w_next_pc   = (r_fetch_pc + 32'd4) & PC_MASK;

`ifdef FETCH_BIG_ENDIAN_EN
  assign w_word = {r_lane0, r_lane1, r_lane2, bus.rom_data};
`else
  assign w_word = {bus.rom_data, r_lane2, r_lane1, r_lane0};
`endif

  // Head is a registered copy so it holds its last value once the FIFO drains;
  // a push into an empty FIFO lands directly in the head.
  always_comb begin
    w_head_word_nxt = r_head_word;
    w_head_pc_nxt   = r_head_pc;
    if (w_rd_nxt != w_wr_nxt) begin
      if (w_push && (w_rd_nxt[AW-1:0] == r_wr_ptr[AW-1:0])) begin
        w_head_word_nxt = w_word;
        w_head_pc_nxt   = r_fetch_pc;
      end else begin
        w_head_word_nxt = r_mem_word[w_rd_nxt[AW-1:0]];
        w_head_pc_nxt   = r_mem_pc[w_rd_nxt[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem_word[r_wr_ptr[AW-1:0]] <= w_word;
      r_mem_pc[r_wr_ptr[AW-1:0]]   <= r_fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FETCH;
      r_fetch_pc  <= START_PC;
      r_byte_cnt  <= '0;
      r_lane0     <= '0;
      r_lane1     <= '0;
      r_lane2     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_head_word <= '0;
      r_head_pc   <= '0;
    end else if (bus.redirect_valid) begin
      r_state    <= FLUSH;
      r_fetch_pc <= bus.redirect_pc & WORD_MASK;
      r_byte_cnt <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_rd_ptr    <= w_rd_nxt;
      r_wr_ptr    <= w_wr_nxt;
      r_head_word <= w_head_word_nxt;
      r_head_pc   <= w_head_pc_nxt;
      unique case (r_state)
        FETCH: begin
          if (r_byte_cnt != 2'd3) begin
            unique case (r_byte_cnt)
              2'd0:    r_lane0 <= bus.rom_data;
              2'd1:    r_lane1 <= bus.rom_data;
              default: r_lane2 <= bus.rom_data;
            endcase
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end else if (w_slot_free) begin
            r_fetch_pc <= w_next_pc;
            r_byte_cnt <= '0;
          end else begin
            r_state <= STALL;
          end
        end
        STALL: begin
          if (w_slot_free) begin
            r_fetch_pc <= w_next_pc;
            r_byte_cnt <= '0;
            r_state    <= FETCH;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  assign bus.rom_addr    = (r_fetch_pc + {30'd0, r_byte_cnt}) & PC_MASK;
  assign bus.instr_valid = !w_empty;
  assign bus.instr_word  = r_head_word;
  assign bus.instr_pc    = r_head_pc;
  assign bus.fetch_pc    = r_fetch_pc;
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected word stream built from the ROM image,
// monitor pops and compares on every decoder handshake.
`timescale 1ns/1ps
module tb_instr_fetch;
  localparam int unsigned ROM_BYTES = 32;
  localparam logic [31:0] MASK = 32'(ROM_BYTES - 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if bus();
  instr_fetch_if bus2();

  instr_fetch #(.RESET_PC(32'h0000_0000), .ROM_BYTES(ROM_BYTES), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  instr_fetch #(.RESET_PC(32'h0000_001C), .ROM_BYTES(ROM_BYTES), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  logic [7:0] rom [ROM_BYTES];
  assign bus.rom_data  = rom[bus.rom_addr[4:0]];
  assign bus2.rom_data = rom[bus2.rom_addr[4:0]];

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_next_pc;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_words  = 0;

  function automatic logic [31:0] ref_word(input logic [31:0] pc);
    logic [7:0] b [4];
    for (int k = 0; k < 4; k++) b[k] = rom[5'((pc + 32'(k)) & MASK)];
`ifdef FETCH_BIG_ENDIAN_EN
    return {b[0], b[1], b[2], b[3]};
`else
    return {b[3], b[2], b[1], b[0]};
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic topup();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{word: ref_word(m_next_pc), pc: m_next_pc});
      m_next_pc = (m_next_pc + 32'd4) & MASK;
    end
  endtask

  // One clock of stimulus; a redirect restarts the expected stream at its word address.
  task automatic drive(input logic rdy, input logic redir, input logic [31:0] rpc);
    @(posedge clk); #1;
    bus.instr_ready    = rdy;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    @(negedge clk); #1;
    if (redir) begin
      exp_q.delete();
      m_next_pc = rpc & ~32'h3 & MASK;
    end
    topup();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    @(negedge clk); #1;
    exp_q.delete();
    m_next_pc = 32'h0;
    topup();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_valid",    {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_word",     bus.instr_word, 32'd0);
    chk("rst_pc",       bus.instr_pc,   32'd0);
    chk("rst_rom_addr", bus.rom_addr,   32'd0);
    chk("rst_fetch_pc", bus.fetch_pc,   32'd0);
  endtask

  // Free run from reset: first word after edge 4, then one per 4 edges.
  task automatic first_words();
    int w0;
    w0 = n_words;
    for (int k = 1; k <= 20; k++) begin
      drive(1'b1, 1'b0, 32'h0);
      if (k <= 4) chk($sformatf("valid_edge%0d", k), {31'd0, bus.instr_valid}, {31'd0, k == 4});
      if (k == 4) begin
        chk("dut2_word0", bus2.instr_word, ref_word(32'h1C));
        chk("dut2_pc0",   bus2.instr_pc,   32'h1C);
      end
      if (k == 8) begin
        chk("dut2_word1", bus2.instr_word, ref_word(32'h00));
        chk("dut2_pc1",   bus2.instr_pc,   32'h00);
      end
    end
    chk("throughput_words", 32'(n_words - w0), 32'd5);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL word_unexpected: got 0x%08h pc 0x%08h expected none",
                   bus.instr_word, bus.instr_pc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("word", bus.instr_word, e.word);
          chk("pc",   bus.instr_pc,   e.pc);
          n_words++;
        end
      end
    end
  end

  initial begin
    #5ms;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    int w0;
    int thresh;
    logic rdy;
    logic redir;
    rst                 = 1'b1;
    bus.instr_ready     = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus2.instr_ready    = 1'b1;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = 32'h0;
    for (int i = 0; i < int'(ROM_BYTES); i++) rom[i] = 8'(i);

    do_reset();
    first_words();

    // Decoder stalled long enough to fill the FIFO and park on byte 3
    do_reset();
    for (int k = 0; k < 30; k++) drive(1'b0, 1'b0, 32'h0);
    chk("stall_valid",    {31'd0, bus.instr_valid}, 32'd1);
    chk("stall_head_pc",  bus.instr_pc,  32'h00);
    chk("stall_rom_addr", bus.rom_addr,  32'h13);
    chk("stall_fetch_pc", bus.fetch_pc,  32'h10);
    w0 = n_words;
    for (int k = 0; k < 30; k++) drive(1'b1, 1'b0, 32'h0);
    chk("stall_release_words", {31'd0, (n_words - w0) >= 5}, 32'd1);

    // Reset while full and stalled
    do_reset();
    for (int k = 0; k < 30; k++) drive(1'b0, 1'b0, 32'h0);
    do_reset();
    first_words();

    // Redirect while two words are queued and a third is half assembled
    do_reset();
    for (int k = 0; k < 10; k++) drive(1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 32'h09);
    drive(1'b0, 1'b0, 32'h0);
    chk("flush_valid",    {31'd0, bus.instr_valid}, 32'd0);
    chk("flush_fetch_pc", bus.fetch_pc, 32'h08);
    chk("flush_hold_pc",  bus.instr_pc, 32'h00);
    drive(1'b1, 1'b0, 32'h0);
    chk("post_flush_valid",    {31'd0, bus.instr_valid}, 32'd0);
    chk("post_flush_rom_addr", bus.rom_addr, 32'h08);
    w0 = n_words;
    for (int k = 0; k < 12; k++) drive(1'b1, 1'b0, 32'h0);
    chk("redirect_words", {31'd0, (n_words - w0) >= 2}, 32'd1);

    // Wrap through the top of the ROM
    drive(1'b1, 1'b1, 32'h1D);
    w0 = n_words;
    for (int k = 0; k < 20; k++) drive(1'b1, 1'b0, 32'h0);
    chk("wrap_words", {31'd0, (n_words - w0) >= 3}, 32'd1);

    // Random ROM, random backpressure and redirects
    for (int i = 0; i < int'(ROM_BYTES); i++) rom[i] = 8'($urandom);
    do_reset();
    w0 = n_words;
    thresh = 60;
    for (int k = 0; k < 2000; k++) begin
      if (k % 200 == 0) thresh = 20 + int'($urandom_range(0, 70));
      rdy   = ($urandom_range(0, 99) < 32'(thresh));
      redir = ($urandom_range(0, 39) == 0);
      drive(rdy, redir, $urandom);
    end
    for (int k = 0; k < 20; k++) drive(1'b1, 1'b0, 32'h0);
    chk("random_words", {31'd0, (n_words - w0) >= 100}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
